// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the RV32I load/store unit: funct3 sizes, fault codes
// and the access FSM states.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10,
    FAULT_ILLEGAL  = 2'b11
  } lsu_fault_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for RV32I accesses: store strobes/data replication,
// load byte/half extraction with sign or zero extension, and access checks.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_val_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  always_comb begin
    byte_sel     = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    is_unsigned  = (funct3_i == F3_LBU) || (funct3_i == F3_LHU);
    illegal_o    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    misaligned_o = 1'b0;
    wstrb_o      = 4'b0000;
    wdata_o      = store_data_i;
    load_val_o   = rdata_i;
    // funct3[1:0] carries the access size; funct3[2] only selects zero-extension.
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_o    = 4'b0001 << addr_lo_i;
        wdata_o    = {4{store_data_i[7:0]}};
        load_val_o = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        misaligned_o = addr_lo_i[0];
        wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{store_data_i[15:0]}};
        load_val_o   = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      2'b10: begin
        misaligned_o = |addr_lo_i;
        wstrb_o      = 4'b1111;
        wdata_o      = store_data_i;
        load_val_o   = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: stalls the core while one access runs over a
// word-wide ready/valid bus, returning aligned load data and a fault code.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic [1:0]        fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  output lsu_state_e        dbg_state
);

  localparam int unsigned       CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q;
  lsu_fault_e        fault_q;
  logic [31:0]       load_data_q;
  logic              bus_req_q, bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_wstrb_q;
  logic [31:0]       bus_wdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]  align_f3;
  logic [1:0]  align_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;
  logic        al_misaligned, al_illegal;

  // Checks use the live request while idle; extraction uses the latched one.
  always_comb begin
    align_f3  = (state_q == IDLE) ? funct3 : f3_q;
    align_off = (state_q == IDLE) ? addr[1:0] : off_q;
    cnt_d     = cnt_q + 1'b1;
  end

  lsu_align u_align (
    .funct3_i     (align_f3),
    .addr_lo_i    (align_off),
    .store_data_i (store_data),
    .rdata_i      (bus_rdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .load_val_o   (al_load),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fault_q     <= FAULT_NONE;
      load_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            if (al_illegal) begin
              fault_q <= FAULT_ILLEGAL;
              state_q <= DONE;
            end else if (al_misaligned) begin
              fault_q <= FAULT_MISALIGN;
              state_q <= DONE;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_write;
              bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wstrb_q <= mem_write ? al_wstrb : 4'b0000;
              bus_wdata_q <= mem_write ? al_wdata : 32'b0;
              f3_q        <= funct3;
              off_q       <= addr[1:0];
              cnt_q       <= '0;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) load_data_q <= al_load;
            fault_q   <= FAULT_NONE;
            state_q   <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            bus_req_q <= 1'b0;
            fault_q   <= FAULT_TIMEOUT;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          fault_q <= FAULT_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall     = mem_valid && (state_q != DONE);
  assign load_data = load_data_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory, randomized
// accesses with a latency-programmable responder, and queued expectations.
module tb_load_store_unit;
  import riscv_lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall;
  logic [1:0]  fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  lsu_state_e  dbg_state;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .fault      (fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .dbg_state  (dbg_state)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  ref_bytes [0:1023];
  logic [31:0] bus_mem [0:255];
  logic [31:0] last_load;
  logic [1:0]  exp_fault_q[$];
  logic [31:0] exp_load_q[$];
  bus_exp_t    exp_bus_q[$];
  int          exp_len_q[$];
  int          wait_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke_word(input int idx, input logic [31:0] v);
    bus_mem[idx] = v;
    for (int k = 0; k < 4; k++) ref_bytes[4*idx+k] = v[8*k +: 8];
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [1:0] ref_fault(input logic [2:0] f3, input logic [31:0] a, input int w);
    int sz;
    sz = ref_size(f3);
    if (sz == 0) return 2'b11;
    if ((int'(a[1:0]) % sz) != 0) return 2'b01;
    if (w >= TMO) return 2'b10;
    return 2'b00;
  endfunction

  // Little-endian assembly from byte memory, then extension by access kind.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = ref_size(f3);
    v  = '0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_bytes[int'(a[9:0]) + k]) << (8*k));
    if ((f3 == F3_LB || f3 == F3_LH) && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int w);
    logic [1:0] f;
    int         sz, n, exp_stall;
    bus_exp_t   be;
    f  = ref_fault(f3, a, w);
    sz = ref_size(f3);
    if (f == 2'b00 && !we) last_load = ref_load(f3, a);
    exp_fault_q.push_back(f);
    exp_load_q.push_back(last_load);
    if (f == 2'b00 || f == 2'b10) begin
      be.addr  = a & ~32'h3;
      be.we    = we;
      be.wstrb = '0;
      be.wdata = '0;
      if (we) begin
        for (int k = 0; k < sz; k++) be.wstrb[int'(a[1:0]) + k] = 1'b1;
        for (int i = 0; i < 4; i++) be.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
      end
      exp_bus_q.push_back(be);
      exp_len_q.push_back((f == 2'b10) ? TMO : w + 1);
      wait_q.push_back(w);
      if (we && f == 2'b00)
        for (int k = 0; k < sz; k++) ref_bytes[int'(a[9:0]) + k] = sd[8*k +: 8];
    end
    exp_stall = (f == 2'b01 || f == 2'b11) ? 1 : ((f == 2'b10) ? TMO + 1 : w + 2);
    mem_valid  = 1'b1;
    mem_write  = we;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall || n > 60) break;
      n++;
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    mem_valid  = 1'b0;
    addr       = $urandom;
    store_data = $urandom;
  endtask

  // Completion monitor: the one non-stalled cycle of a presented access.
  initial begin
    logic [1:0]  ef;
    logic [31:0] el;
    forever begin
      @(negedge clk);
      if (!reset && mem_valid && !stall) begin
        if (exp_fault_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          ef = exp_fault_q.pop_front();
          el = exp_load_q.pop_front();
          check("fault", 32'(fault), 32'(ef));
          check("load_data", load_data, el);
        end
      end
    end
  end

  // Bus monitor: request contents on the first cycle, stability after, length at drop.
  initial begin
    logic     prev_req;
    int       req_cnt;
    bus_exp_t cur;
    prev_req = 1'b0;
    req_cnt  = 0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (!prev_req) begin
          req_cnt = 1;
          if (exp_bus_q.size() == 0) begin
            check("unexpected_bus_req", 32'(1), 32'(0));
          end else begin
            cur = exp_bus_q.pop_front();
            check("bus_addr", bus_addr, cur.addr);
            check("bus_we", 32'(bus_we), 32'(cur.we));
            check("bus_wstrb", 32'(bus_wstrb), 32'(cur.wstrb));
            if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
          end
        end else begin
          req_cnt++;
          check("bus_addr_stable", bus_addr, cur.addr);
        end
      end else if (prev_req) begin
        if (exp_len_q.size() == 0) check("unexpected_req_drop", 32'(1), 32'(0));
        else check("req_len", 32'(req_cnt), 32'(exp_len_q.pop_front()));
      end
      prev_req = bus_req;
    end
  end

  // Memory responder: asserts ready after the queued number of wait cycles.
  initial begin
    logic active;
    int   rcnt;
    active    = 1'b0;
    rcnt      = 0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req && !reset) begin
        if (!active) begin
          active = 1'b1;
          rcnt   = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
        if (rcnt == 0) begin
          bus_ready = 1'b1;
          bus_rdata = bus_mem[bus_addr[9:2]];
          if (bus_we)
            for (int i = 0; i < 4; i++)
              if (bus_wstrb[i]) bus_mem[bus_addr[9:2]][8*i +: 8] = bus_wdata[8*i +: 8];
        end else begin
          rcnt--;
          bus_ready = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        active    = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end
    end
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [2:0]  f3;
    logic [2:0]  lf [5];
    logic [31:0] a, v;
    logic        we;
    int          sz, w, n;
    lf = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    reset      = 1'b1;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    funct3     = '0;
    addr       = '0;
    store_data = '0;
    last_load  = '0;
    for (int i = 0; i < 256; i++) poke_word(i, $urandom);
    repeat (2) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_bus_req", 32'(bus_req), 32'(0));
    check("rst_load_data", load_data, 32'h0);
    check("rst_fault", 32'(fault), 32'(0));
    check("rst_wstrb", 32'(bus_wstrb), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    poke_word(64, 32'hDEADBEEF);
    do_access(1'b0, F3_LW, 32'h100, 32'h0, 0);
    check("lw_value", load_data, 32'hDEADBEEF);
    poke_word(64, 32'h80FF1234);
    do_access(1'b0, F3_LB, 32'h103, 32'h0, 1);
    check("lb_value", load_data, 32'hFFFFFF80);
    do_access(1'b0, F3_LBU, 32'h103, 32'h0, 2);
    check("lbu_value", load_data, 32'h00000080);
    do_access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 0);
    do_access(1'b1, 3'b010, 32'h105, 32'h12345678, 0);
    do_access(1'b0, F3_LW, 32'h104, 32'h0, TMO + 3);
    check("timeout_keeps_load", load_data, 32'h00000080);
    do_access(1'b0, 3'b011, 32'h10, 32'h0, 0);
    do_access(1'b1, 3'b110, 32'h20, 32'h55, 0);
    do_access(1'b0, F3_LH, 32'h1, 32'h0, 0);

    // Reset in the middle of a stalled request abandons it.
    exp_bus_q.push_back('{addr: 32'h10, we: 1'b0, wstrb: 4'b0, wdata: 32'h0});
    exp_len_q.push_back(3);
    wait_q.push_back(50);
    mem_valid = 1'b1;
    mem_write = 1'b0;
    funct3    = F3_LW;
    addr      = 32'h10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_req && n < 20);
    repeat (2) @(negedge clk);
    #1;
    reset     = 1'b1;
    mem_valid = 1'b0;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'(0));
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    check("mid_rst_bus_addr", bus_addr, 32'h0);
    check("mid_rst_bus_we", 32'(bus_we), 32'(0));
    check("mid_rst_load", load_data, 32'h0);
    check("mid_rst_fault", 32'(fault), 32'(0));
    last_load = '0;
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    poke_word(0, 32'h00000001);
    do_access(1'b0, F3_LW, 32'h0, 32'h0, 0);
    check("post_rst_lw", load_data, 32'h00000001);

    for (int t = 0; t < 250; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        n  = $urandom_range(0, 2);
        f3 = (n == 0) ? 3'b011 : ((n == 1) ? 3'b110 : 3'b111);
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        f3 = lf[$urandom_range(0, 4)];
      end
      a  = 32'($urandom_range(0, 1023));
      sz = ref_size(f3);
      if (sz > 0 && $urandom_range(0, 3) != 0) a = a - 32'(int'(a[1:0]) % sz);
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
      do_access(we, f3, a, $urandom, w);
      n = $urandom_range(0, 2);
      if (n != 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    check("done_q_drained", 32'(exp_fault_q.size()), 32'(0));
    check("bus_q_drained", 32'(exp_bus_q.size()), 32'(0));
    check("len_q_drained", 32'(exp_len_q.size()), 32'(0));
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_bytes[4*i+k];
      check("mem_word", bus_mem[i], v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle datapath's ALU; consumes ALU_result (effective address) and write_data (rs2).
- Performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a word-wide ready/valid memory bus.
- Stalls the core until the access completes, then returns the aligned, extended load value to the result mux (read_data input of the datapath).
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255: number of bus_req-high cycles without bus_ready before the access is aborted. Must be ≥1.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  core presents a load/store this cycle (held until stall drops)
- mem_write  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign field
- addr  in  ADDR_W  effective byte address (ALU_result)
- store_data  in  32  rs2 value (write_data)
- load_data  out  32  extended load result, registered
- stall  out  1  core must hold PC and instruction
- fault  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3; valid in DONE only
- bus_req  out  1  request valid, registered
- bus_we  out  1  write enable
- bus_addr  out  ADDR_W  word-aligned address (addr with [1:0] forced to 0)
- bus_wstrb  out  4  byte-lane write strobes
- bus_wdata  out  32  lane-replicated store data
- bus_ready  in  1  memory accepts/completes the transfer this cycle
- bus_rdata  in  32  read word, valid when bus_req && bus_ready

Behaviour:
- One clock domain; asynchronous reset applies in all states.
- Reset: state IDLE; load_data, fault, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata and the timeout counter all 0.
- FSM states: IDLE, REQ, DONE.
- stall = mem_valid && (state != DONE). Combinational, so the core stalls in the same cycle it presents the access.
- IDLE with mem_valid: check the access.
  - Illegal funct3 (011, 110, 111) -> DONE, fault=11.
  - Misaligned -> DONE, fault=01. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - Otherwise -> REQ. Latch bus_addr, bus_we, bus_wstrb, bus_wdata; set bus_req=1; clear the counter.
  - A faulted access never asserts bus_req.
- REQ:
  - bus_ready=1: transfer completes at that edge. bus_req=0; for a load, capture the extracted value into load_data; -> DONE, fault=00.
  - bus_ready=0: counter += 1. When counter reaches TIMEOUT_CYCLES-1 with no ready: bus_req=0, -> DONE, fault=10, load_data unchanged.
- DONE: stall=0 for exactly one cycle and the core advances. Next edge -> IDLE; fault clears to 00 on that edge. The next access is accepted at the earliest in the cycle after DONE.
- Minimum latency for a legal access: 3 cycles (IDLE accept, REQ with ready, DONE).
- Bus outputs stay stable while bus_req=1. Inputs sampled after acceptance are ignored.
- Store alignment:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 1111, wdata = store_data.
  - Loads drive wstrb = 0000.
- Load extraction: select the byte or half at addr[1:0] from bus_rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stores leave load_data unchanged.
- Reset asserted mid-REQ: bus_req drops immediately (async), the FSM returns to IDLE, and the transaction is abandoned. The memory side must tolerate a dropped request.
- mem_valid deasserting in REQ (protocol violation): the access still completes; the result is discarded.

Decomposition:
- Package riscv_lsu_pkg holds:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101 (stores reuse 000/001/010);
  - fault codes FAULT_NONE/MISALIGN/TIMEOUT/ILLEGAL;
  - state enum IDLE/REQ/DONE.
- One combinational sub-module, lsu_align, with inputs funct3, addr[1:0], store_data and bus_rdata. It produces wstrb, wdata, load value and misaligned/illegal flags.
- load_store_unit holds the FSM, timeout counter ($clog2(TIMEOUT_CYCLES) bits) and registers.

Test Plan:
- LW at addr 0x100, bus_rdata=0xDEADBEEF, bus_ready on the first REQ cycle -> bus_addr=0x100, stall high 2 cycles, load_data=0xDEADBEEF, fault=00.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF_1234 -> load_data=0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, store_data=0x0000ABCD -> bus_wstrb=1100, bus_wdata=0xABCDABCD, bus_addr=0x200, bus_we=1.
- SW at 0x105 -> no bus_req, one stall cycle then DONE with fault=01, memory untouched.
- TIMEOUT_CYCLES=4 with bus_ready held 0 -> bus_req high exactly 4 cycles, then fault=10, load_data unchanged.
- Assert reset during REQ with bus_ready=0 -> bus_req=0 immediately, state IDLE, all outputs 0. A following LW at 0x0 with rdata=0x1 completes normally with load_data=0x00000001.
